// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, legal prescale
// ratios and parity-type constants common to the RX and TX sides.
package uart_pkg;

  localparam int UART_WIDTH  = 8;
  localparam int UART_PRES_W = 6;

  localparam logic [UART_PRES_W-1:0] PRES_8  = 6'd8;
  localparam logic [UART_PRES_W-1:0] PRES_16 = 6'd16;
  localparam logic [UART_PRES_W-1:0] PRES_32 = 6'd32;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversample timing for the UART receiver: per-bit edge counter, frame bit counter
// and a 3-sample majority vote taken around the middle of each bit.
module uart_rx_sampler import uart_pkg::*; #(
  parameter int PRES_W = UART_PRES_W,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic              run_i,
  input  logic              rx_i,
  input  logic [PRES_W-1:0] prescale_i,
  output logic              sampled_bit_o,
  output logic              sample_done_o,
  output logic              bit_end_o,
  output logic [CNT_W-1:0]  bit_cnt_o
);

  localparam logic [PRES_W-1:0] ONE = PRES_W'(1);
  localparam logic [PRES_W-1:0] TWO = PRES_W'(2);

  logic [PRES_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRES_W-1:0] half;
  logic [2:0]        smp_q;
  logic              wrap;

  assign half = prescale_i >> 1;
  assign wrap = run_i && (edge_cnt_q == prescale_i - ONE);

  // The start-detect cycle is edge 0, so the counter leaves it already at 1.
  always_comb begin
    edge_cnt_d = '0;
    bit_cnt_d  = '0;
    if (start_i) begin
      edge_cnt_d = ONE;
    end else if (run_i) begin
      edge_cnt_d = wrap ? '0 : edge_cnt_q + ONE;
      bit_cnt_d  = wrap ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (run_i) begin
      if (edge_cnt_q == half - ONE) smp_q[0] <= rx_i;
      if (edge_cnt_q == half)       smp_q[1] <= rx_i;
      if (edge_cnt_q == half + ONE) smp_q[2] <= rx_i;
    end
  end

  assign sampled_bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign sample_done_o = run_i && (edge_cnt_q == half + TWO);
  assign bit_end_o     = wrap;
  assign bit_cnt_o     = bit_cnt_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: frame FSM, LSB-first shift register, parity/stop checking and
// registered single-cycle result pulses.
module uart_rx_core import uart_pkg::*; #(
  parameter int WIDTH  = UART_WIDTH,
  parameter int PRES_W = UART_PRES_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [PRES_W-1:0] PRESCALE,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [WIDTH-1:0]  P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STP_ERR
);

  localparam int CNT_W = $clog2(WIDTH + 3);

  rx_state_e         state_q, state_d;
  logic [PRES_W-1:0] pres_q;
  logic              par_en_q, par_typ_q;
  logic              par_flag_q, par_flag_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  p_data_q, p_data_d;
  logic              dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
  logic              start, running, sampled_bit, sample_done, bit_end;
  logic [CNT_W-1:0]  bit_cnt;

  assign running = (state_q != IDLE);
  assign start   = (state_q == IDLE) && !RX_IN;

  uart_rx_sampler #(
    .PRES_W(PRES_W),
    .CNT_W (CNT_W)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .start_i      (start),
    .run_i        (running),
    .rx_i         (RX_IN),
    .prescale_i   (pres_q),
    .sampled_bit_o(sampled_bit),
    .sample_done_o(sample_done),
    .bit_end_o    (bit_end),
    .bit_cnt_o    (bit_cnt)
  );

  // bit_cnt is 0 during the start bit, so data bits occupy 1..WIDTH.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    par_flag_d = par_flag_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START;
          par_flag_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (sample_done) shadow_d = {sampled_bit, shadow_q[WIDTH-1:1]};
        if (bit_end && bit_cnt == CNT_W'(WIDTH)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) begin
          par_flag_d = sampled_bit ^ (^shadow_q) ^ par_typ_q;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (!par_flag_q && sampled_bit) begin
            dv_d     = 1'b1;
            p_data_d = shadow_q;
          end else begin
            perr_d = par_flag_q;
            serr_d = !sampled_bit;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      pres_q     <= PRES_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= EVEN;
      par_flag_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_flag_q <= par_flag_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      if (start) begin
        pres_q    <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  always_ff @(posedge CLK) begin
    shadow_q <= shadow_d;
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = perr_q;
  assign STP_ERR    = serr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level model predicts the result pulse cycle and
// contents of every frame; outputs are compared on every falling clock edge.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = PRES_8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = EVEN;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_dv = 0, n_perr = 0, n_serr = 0;
  int dv_cyc[$];

  // Expected result per cycle: {dv, perr, serr, byte}
  logic [10:0] ev[int];
  logic [7:0]  exp_pdata = 8'h00;

  uart_rx_core #(.WIDTH(8), .PRES_W(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [10:0] e;
    if (!RST) begin
      exp_pdata = 8'h00;
      e = 11'h000;
    end else if (ev.exists(cyc)) begin
      e = ev[cyc];
      if (e[10]) exp_pdata = e[7:0];
      e[7:0] = exp_pdata;
      ev.delete(cyc);
    end else begin
      e = {3'b000, exp_pdata};
    end
    check("cycle_outputs", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}, {21'd0, e});
    if (DATA_VALID) begin
      n_dv++;
      dv_cyc.push_back(cyc);
    end
    if (PAR_ERR) n_perr++;
    if (STP_ERR) n_serr++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic v);
    @(posedge CLK);
    #1;
    RX_IN = v;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  function automatic int pick_pres();
    int sel;
    sel = $urandom_range(0, 2);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
  endfunction

  // Drives one frame; abort_at>0 pulls reset that many cycles after the start edge.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                            input logic bad_par, input logic bad_stop, input logic glitchy,
                            input int abort_at);
    logic bits[$];
    logic pbit, perr, serr, v;
    int   nb, s;
    pbit = (^d) ^ pt ^ bad_par;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(!bad_stop);
    nb   = bits.size();
    perr = pe && (pbit != ((^d) ^ pt));
    serr = bad_stop;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < p; e++) begin
        v = bits[b];
        if (glitchy && b >= 1 && b <= 8 && e == 1) v = ~v;
        tick(v);
        if (b == 0 && e == 0) begin
          s = cyc;
          PRESCALE = 6'(p);
          PAR_EN   = pe;
          PAR_TYP  = pt;
          ev[s + nb * p] = {!perr && !serr, perr, serr, d};
        end else if (b == 0 && e == 1) begin
          PRESCALE = 6'(pick_pres());
          PAR_EN   = 1'($urandom_range(0, 1));
          PAR_TYP  = 1'($urandom_range(0, 1));
        end
        if (abort_at > 0 && b * p + e == abort_at) begin
          RST = 1'b0;
          ev.delete();
          #1;
          check("rst_async", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}, 32'd0);
          RX_IN = 1'b1;
          repeat (3) @(posedge CLK);
          #1;
          RST = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic glitch_low(input int n, input int p);
    tick(1'b0);
    PRESCALE = 6'(p);
    repeat (n - 1) tick(1'b0);
    idle(p + 2);
  endtask

  initial begin
    int b_dv, b_pe, b_se, p, nb, ab;
    logic pe, pt;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}, 32'd0);
    RST = 1'b1;
    idle(4);

    // Directed frames
    b_dv = n_dv;
    send_frame(8'hA5, 8, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
    check("t1_pdata", P_DATA, 8'hA5);
    check("t1_dv_once", n_dv - b_dv, 1);

    b_dv = n_dv;
    send_frame(8'h3C, 16, 1'b1, ODD, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
    check("t2_pdata", P_DATA, 8'h3C);
    send_frame(8'h81, 32, 1'b0, EVEN, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
    check("t2_pdata_p32", P_DATA, 8'h81);
    check("t2_dv_count", n_dv - b_dv, 2);

    send_frame(8'hA5, 8, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
    b_dv = n_dv; b_pe = n_perr;
    send_frame(8'hA5, 8, 1'b1, EVEN, 1'b1, 1'b0, 1'b0, 0);
    idle(2);
    check("t3_pdata_held", P_DATA, 8'hA5);
    check("t3_perr_once", n_perr - b_pe, 1);
    check("t3_no_dv", n_dv - b_dv, 0);

    b_dv = n_dv; b_se = n_serr; b_pe = n_perr;
    send_frame(8'h55, 8, 1'b1, EVEN, 1'b0, 1'b1, 1'b0, 0);
    idle(2);
    check("t4_serr_once", n_serr - b_se, 1);
    check("t4_no_dv", n_dv - b_dv, 0);
    glitch_low(2, 8);
    idle(4);
    check("t4_glitch_quiet", (n_dv - b_dv) + (n_perr - b_pe) + (n_serr - b_se - 1), 0);

    send_frame(8'h12, 8, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'hF0, 8, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
    check("t5_pdata", P_DATA, 8'hF0);
    check("t5_spacing", dv_cyc[$] - dv_cyc[$-1], 88);

    send_frame(8'h7E, 8, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 5 * 8 + 2);
    idle(4);
    check("t6_pdata_cleared", P_DATA, 8'h00);
    send_frame(8'h7E, 8, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
    check("t6_pdata", P_DATA, 8'h7E);

    // Randomized frames, gaps, glitches and resets
    for (int k = 0; k < 80; k++) begin
      p  = pick_pres();
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      nb = pe ? 11 : 10;
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, nb * p - 1) : 0;
      if ($urandom_range(0, 9) == 0)
        glitch_low($urandom_range(1, 2), p);
      else
        send_frame(8'($urandom), p, pe, pt, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, ab);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
    end

    idle(40);
    check("pending_events", ev.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
